// File: rtl/elevator_pkg.sv
// Shared elevator definitions: floor geometry, direction codes, scheduler
// state encoding and floor-mask helpers.
package elevator_pkg;

    localparam int NUM_FLOORS = 8;
    localparam int FLOOR_W    = 3;

    localparam logic [1:0] DIR_IDLE = 2'd0;
    localparam logic [1:0] DIR_UP   = 2'd1;
    localparam logic [1:0] DIR_DOWN = 2'd2;

    // State codes equal the direction codes, so the state register drives direct.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } sched_state_t;

    typedef logic [NUM_FLOORS-1:0] floor_mask_t;

    // The top floor has no up button and the ground floor has no down button.
    localparam floor_mask_t HALL_UP_VALID = {1'b0, {(NUM_FLOORS-1){1'b1}}};
    localparam floor_mask_t HALL_DN_VALID = {{(NUM_FLOORS-1){1'b1}}, 1'b0};

    function automatic floor_mask_t above_mask(input logic [FLOOR_W-1:0] f);
        floor_mask_t m;
        m = '0;
        for (int i = 0; i < NUM_FLOORS; i++) m[i] = (i > int'(f));
        return m;
    endfunction

    function automatic floor_mask_t below_mask(input logic [FLOOR_W-1:0] f);
        floor_mask_t m;
        m = '0;
        for (int i = 0; i < NUM_FLOORS; i++) m[i] = (i < int'(f));
        return m;
    endfunction

endpackage

// File: rtl/call_scheduler_if.sv
// Scheduler bus: call inputs and car position from the panel/motion side,
// pending-call lamps, direction and stop/park indications back.
interface call_scheduler_if;
    import elevator_pkg::*;

    floor_mask_t          car_btn;
    floor_mask_t          hall_up;
    floor_mask_t          hall_dn;
    logic [FLOOR_W-1:0]   car_floor;
    logic                 arrive;

    floor_mask_t          floor_req;
    floor_mask_t          car_lamp;
    floor_mask_t          up_lamp;
    floor_mask_t          dn_lamp;
    logic [1:0]           direct;
    logic                 stop_here;
    logic                 park_req;

    modport master (
        output car_btn, hall_up, hall_dn, car_floor, arrive,
        input  floor_req, car_lamp, up_lamp, dn_lamp, direct, stop_here, park_req
    );

    modport slave (
        input  car_btn, hall_up, hall_dn, car_floor, arrive,
        output floor_req, car_lamp, up_lamp, dn_lamp, direct, stop_here, park_req
    );

endinterface

// File: rtl/call_reg.sv
// Per-floor pending-call register: pulses set bits, clears win over sets.
module call_reg
    import elevator_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  floor_mask_t set_mask,
    input  floor_mask_t clr_mask,
    output floor_mask_t q
);

    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) q <= '0;
        else        q <= (q | set_mask) & ~clr_mask;
    end

endmodule

// File: rtl/call_scheduler.sv
// Elevator call scheduler: latches calls, picks a service direction,
// flags stops at the current floor and parks an idle car at floor 0.
module call_scheduler
    import elevator_pkg::*;
#(
    parameter int PARK_CYCLES = 30
) (
    input  logic            clk,
    input  logic            reset,
    call_scheduler_if.slave bus
);

    localparam int CNT_W = (PARK_CYCLES > 1) ? $clog2(PARK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((PARK_CYCLES > 0) ? PARK_CYCLES - 1 : 0);

    sched_state_t      state, state_nxt;
    floor_mask_t       car_q, up_q, dn_q, pending, cur_bit;
    floor_mask_t       car_set, up_set, dn_set;
    floor_mask_t       car_clr, up_clr, dn_clr;
    logic              above, below, ahead;
    logic              idle_qual, park_hit, park_q;
    logic [CNT_W-1:0]  idle_cnt;

    assign pending = car_q | up_q | dn_q;
    assign cur_bit = floor_mask_t'(1) << bus.car_floor;
    assign above   = |(pending & above_mask(bus.car_floor));
    assign below   = |(pending & below_mask(bus.car_floor));

    assign car_set = bus.car_btn | floor_mask_t'(park_hit);
    assign up_set  = bus.hall_up & HALL_UP_VALID;
    assign dn_set  = bus.hall_dn & HALL_DN_VALID;

    // Hall bits for the opposite direction are only kept while there is work beyond.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        car_clr = '0;
        up_clr  = '0;
        dn_clr  = '0;
        if (bus.arrive) begin
            car_clr = cur_bit;
            case (state)
                ST_UP: begin
                    up_clr = cur_bit;
                    if (!above) dn_clr = cur_bit;
                end
                ST_DOWN: begin
                    dn_clr = cur_bit;
                    if (!below) up_clr = cur_bit;
                end
                default: begin
                    up_clr = cur_bit;
                    dn_clr = cur_bit;
                end
            endcase
        end
    end

    call_reg u_car_reg (.clk(clk), .reset(reset), .set_mask(car_set), .clr_mask(car_clr), .q(car_q));
    call_reg u_up_reg  (.clk(clk), .reset(reset), .set_mask(up_set),  .clr_mask(up_clr),  .q(up_q));
    call_reg u_dn_reg  (.clk(clk), .reset(reset), .set_mask(dn_set),  .clr_mask(dn_clr),  .q(dn_q));

    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_UP:   state_nxt = above ? ST_UP   : (below ? ST_DOWN : ST_IDLE);
            ST_DOWN: state_nxt = below ? ST_DOWN : (above ? ST_UP   : ST_IDLE);
            default: state_nxt = above ? ST_UP   : (below ? ST_DOWN : ST_IDLE);
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    assign idle_qual = (state == ST_IDLE) && (pending == '0) && (bus.car_floor != '0);
    assign park_hit  = (PARK_CYCLES > 0) && idle_qual && (idle_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt <= '0;
            park_q   <= 1'b0;
        end else begin
            park_q <= park_hit;
            if (!idle_qual || park_hit || PARK_CYCLES == 0) idle_cnt <= '0;
            else                                            idle_cnt <= idle_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        ahead = 1'b0;
        case (state)
            ST_UP:   ahead = above;
            ST_DOWN: ahead = below;
            default: ahead = 1'b0;
        endcase
    end

    assign bus.stop_here = car_q[bus.car_floor]
                         | ((state == ST_UP)   && up_q[bus.car_floor])
                         | ((state == ST_DOWN) && dn_q[bus.car_floor])
                         | (((state == ST_IDLE) || !ahead) && pending[bus.car_floor]);

    assign bus.floor_req = pending;
    assign bus.car_lamp  = car_q;
    assign bus.up_lamp   = up_q;
    assign bus.dn_lamp   = dn_q;
    assign bus.direct    = state;
    assign bus.park_req  = park_q;

endmodule
